// File: rtl/pc_sequencer_if.sv
// Memory handshake bundle between pc_sequencer (master) and the instruction/data memories (slave).
// A request stays high while the memory is working; a ready is sampled only while its request is high.
interface pc_sequencer_if;
   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_ready;

   modport master (
      output imem_req,
      output dmem_req,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      output imem_ready,
      output dmem_ready
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: drives pccalc's stay, gates commit, handles halt/timeout, counts retirements.
// Optional single-step support is compiled in with `define PC_SEQ_STEP_EN.
module pc_sequencer #(
   parameter int BOOT_DELAY = 2,
   parameter int TIMEOUT    = 15
) (
   input  logic                 clk,
   input  logic                 rstn,
   pc_sequencer_if.master       mem,
   input  logic                 dmem_access,
   input  logic                 halt_req,
   input  logic                 resume,
`ifdef PC_SEQ_STEP_EN
   input  logic                 step_mode,
   input  logic                 step,
`endif
   output logic                 stay,
   output logic                 commit,
   output logic                 halted,
   output logic                 fault,
   output logic [2:0]           state,
   output logic [31:0]          retire_cnt
);

   typedef enum logic [2:0] {
      S_BOOT      = 3'd0,
      S_FETCH     = 3'd1,
      S_EXEC      = 3'd2,
      S_MEM       = 3'd3,
      S_HALT      = 3'd4,
      S_FAULT     = 3'd5,
      S_STEP_WAIT = 3'd6
   } state_t;

   // BOOT_DELAY of 0 or 1 both leave BOOT after a single cycle.
   localparam logic [31:0] BOOT_LAST  = (BOOT_DELAY > 1) ? 32'(BOOT_DELAY - 1) : 32'd0;
   localparam logic [31:0] TO_LAST    = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
   localparam bit          TO_ENABLED = (TIMEOUT != 0);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] boot_cnt;
   logic [31:0] wait_cnt;
   logic        timed_out;
   logic        step_hold;
   logic        step_go;
   state_t      after_commit;

`ifdef PC_SEQ_STEP_EN
   assign step_hold = step_mode;
   assign step_go   = step;
`else
   assign step_hold = 1'b0;
   assign step_go   = 1'b1;
`endif

   assign timed_out    = TO_ENABLED && (wait_cnt == TO_LAST);
   assign after_commit = step_hold ? S_STEP_WAIT : S_FETCH;

   always_comb begin
      state_d = state_q;
      stay    = 1'b1;
      commit  = 1'b0;
      case (state_q)
         S_BOOT: begin
            if (boot_cnt == BOOT_LAST) state_d = S_FETCH;
         end
         S_FETCH: begin
            // ready beats a coinciding timeout
            if (mem.imem_ready)  state_d = S_EXEC;
            else if (timed_out)  state_d = S_FAULT;
         end
         S_EXEC: begin
            if (halt_req)         state_d = S_HALT;
            else if (dmem_access) state_d = S_MEM;
            else begin
               commit  = 1'b1;
               stay    = 1'b0;
               state_d = after_commit;
            end
         end
         S_MEM: begin
            if (mem.dmem_ready) begin
               commit  = 1'b1;
               stay    = 1'b0;
               state_d = after_commit;
            end else if (timed_out) begin
               state_d = S_FAULT;
            end
         end
         S_HALT: begin
            // one stay=0 cycle steps the PC past the halting instruction
            if (resume) begin
               stay    = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FAULT: state_d = S_FAULT;
         S_STEP_WAIT: begin
            if (step_go) state_d = S_FETCH;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_BOOT;
         boot_cnt   <= 32'd0;
         wait_cnt   <= 32'd0;
         retire_cnt <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_BOOT) boot_cnt <= boot_cnt + 32'd1;
         if (state_d != state_q)
            wait_cnt <= 32'd0;
         else if (state_q == S_FETCH || state_q == S_MEM)
            wait_cnt <= wait_cnt + 32'd1;
         if (commit) retire_cnt <= retire_cnt + 32'd1;
      end
   end

   assign mem.imem_req = (state_q == S_FETCH);
   assign mem.dmem_req = (state_q == S_MEM);
   assign halted       = (state_q == S_HALT);
   assign fault        = (state_q == S_FAULT);
   assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, ALU stream, load latency, timeout, halt/resume, reset in MEM.
// A second instance (BOOT_DELAY=0, TIMEOUT=0) covers the disabled-timeout and zero boot delay corners.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        dmem_access;
   logic        halt_req;
   logic        resume;
   logic        stay;
   logic        commit;
   logic        halted;
   logic        fault;
   logic [2:0]  state;
   logic [31:0] retire_cnt;
`ifdef PC_SEQ_STEP_EN
   logic        step_mode;
   logic        step;
`endif

   logic        nt_zero;
   logic        nt_stay;
   logic        nt_commit;
   logic        nt_halted;
   logic        nt_fault;
   logic [2:0]  nt_state;
   logic [31:0] nt_retire_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   pc_sequencer_if m ();
   pc_sequencer_if nt ();

   // clock / reset
   always #5 clk = ~clk;

   pc_sequencer #(.BOOT_DELAY(2), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .mem         (m.master),
      .dmem_access (dmem_access),
      .halt_req    (halt_req),
      .resume      (resume),
`ifdef PC_SEQ_STEP_EN
      .step_mode   (step_mode),
      .step        (step),
`endif
      .stay        (stay),
      .commit      (commit),
      .halted      (halted),
      .fault       (fault),
      .state       (state),
      .retire_cnt  (retire_cnt)
   );

   pc_sequencer #(.BOOT_DELAY(0), .TIMEOUT(0)) dut_nt (
      .clk         (clk),
      .rstn        (rstn),
      .mem         (nt.master),
      .dmem_access (nt_zero),
      .halt_req    (nt_zero),
      .resume      (nt_zero),
`ifdef PC_SEQ_STEP_EN
      .step_mode   (nt_zero),
      .step        (nt_zero),
`endif
      .stay        (nt_stay),
      .commit      (nt_commit),
      .halted      (nt_halted),
      .fault       (nt_fault),
      .state       (nt_state),
      .retire_cnt  (nt_retire_cnt)
   );

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn         = 1'b0;
      dmem_access  = 1'b0;
      halt_req     = 1'b0;
      resume       = 1'b0;
      nt_zero      = 1'b0;
      m.imem_ready = 1'b1;
      m.dmem_ready = 1'b0;
      nt.imem_ready = 1'b0;
      nt.dmem_ready = 1'b0;
`ifdef PC_SEQ_STEP_EN
      step_mode = 1'b0;
      step      = 1'b0;
`endif

      // reset values
      #1;
      chk("rst_state",  32'(state), 0);
      chk("rst_stay",   32'(stay), 1);
      chk("rst_imem",   32'(m.imem_req), 0);
      chk("rst_dmem",   32'(m.dmem_req), 0);
      chk("rst_commit", 32'(commit), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_fault",  32'(fault), 0);
      chk("rst_retire", retire_cnt, 0);
      repeat (2) @(posedge clk);

      // boot: imem_req rises two edges after release
      release_reset();
      tick();
      chk("boot1_state", 32'(state), 0);
      chk("boot1_imem",  32'(m.imem_req), 0);
      chk("nt_boot0_state", 32'(nt_state), 1);
      tick();
      chk("boot2_state", 32'(state), 1);
      chk("boot2_imem",  32'(m.imem_req), 1);

      // ALU stream: four instructions, stay pulses low every second cycle
      for (int i = 0; i < 4; i++) begin
         chk("alu_fetch_state", 32'(state), 1);
         chk("alu_fetch_stay",  32'(stay), 1);
         tick();
         chk("alu_exec_state",  32'(state), 2);
         chk("alu_exec_stay",   32'(stay), 0);
         chk("alu_exec_commit", 32'(commit), 1);
         tick();
      end
      chk("alu_retire", retire_cnt, 4);

      // load with three-cycle data latency: states 1,2,3,3,3,1
      exp_q = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd1};
      dmem_access = 1'b1;
      chk("ld_state0", 32'(state), exp_q.pop_front());
      tick();
      chk("ld_state1", 32'(state), exp_q.pop_front());
      chk("ld_exec_commit", 32'(commit), 0);
      chk("ld_exec_stay",   32'(stay), 1);
      tick();
      chk("ld_state2", 32'(state), exp_q.pop_front());
      chk("ld_dmem_req", 32'(m.dmem_req), 1);
      tick();
      chk("ld_state3", 32'(state), exp_q.pop_front());
      chk("ld_wait_commit", 32'(commit), 0);
      tick();
      chk("ld_state4", 32'(state), exp_q.pop_front());
      m.dmem_ready = 1'b1;
      #1;
      chk("ld_done_commit", 32'(commit), 1);
      chk("ld_done_stay",   32'(stay), 0);
      tick();
      m.dmem_ready = 1'b0;
      dmem_access  = 1'b0;
      chk("ld_state5", 32'(state), exp_q.pop_front());
      chk("ld_retire", retire_cnt, 5);
      chk("ld_fault",  32'(fault), 0);

      // timeout: 15 not-ready FETCH cycles lead to FAULT
      m.imem_ready = 1'b0;
      repeat (14) tick();
      chk("to_15th_state", 32'(state), 1);
      chk("to_15th_fault", 32'(fault), 0);
      tick();
      chk("to_state", 32'(state), 5);
      chk("to_fault", 32'(fault), 1);
      chk("to_imem",  32'(m.imem_req), 0);
      m.imem_ready = 1'b1;
      resume = 1'b1;
      repeat (3) tick();
      resume = 1'b0;
      chk("fault_sticky", 32'(state), 5);

      // ready on the 15th cycle wins over the timeout
      rstn = 1'b0;
      #1;
      chk("rst_from_fault", 32'(state), 0);
      release_reset();
      tick();
      tick();
      chk("rb_state", 32'(state), 1);
      m.imem_ready = 1'b0;
      repeat (14) tick();
      m.imem_ready = 1'b1;
      tick();
      chk("ready15_state", 32'(state), 2);
      chk("ready15_fault", 32'(fault), 0);

      // halt beats dmem_access; no commit, retire unchanged
      halt_req    = 1'b1;
      dmem_access = 1'b1;
      #1;
      chk("halt_exec_commit", 32'(commit), 0);
      chk("halt_exec_stay",   32'(stay), 1);
      tick();
      halt_req    = 1'b0;
      dmem_access = 1'b0;
      chk("halt_state",  32'(state), 4);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_retire", retire_cnt, 0);
      tick();
      chk("halt_hold_stay", 32'(stay), 1);
      resume = 1'b1;
      #1;
      chk("resume_stay",   32'(stay), 0);
      chk("resume_commit", 32'(commit), 0);
      tick();
      resume = 1'b0;
      chk("resume_state", 32'(state), 1);
      chk("resume_stay_after", 32'(stay), 1);
      chk("resume_retire", retire_cnt, 0);

      // reset while in MEM
      tick();
      tick();
      chk("pre_mem_retire", retire_cnt, 1);
      dmem_access = 1'b1;
      tick();
      tick();
      chk("mem_state", 32'(state), 3);
      chk("mem_dmem_req", 32'(m.dmem_req), 1);
      #1;
      rstn = 1'b0;
      #1;
      chk("rst_mem_state",  32'(state), 0);
      chk("rst_mem_dmem",   32'(m.dmem_req), 0);
      chk("rst_mem_retire", retire_cnt, 0);
      chk("rst_mem_commit", 32'(commit), 0);
      dmem_access = 1'b0;
      release_reset();
      tick();
      tick();
      chk("post_rst_state", 32'(state), 1);

`ifdef PC_SEQ_STEP_EN
      // single-step parks in STEP_WAIT after a commit
      step_mode = 1'b1;
      tick();
      chk("step_exec_commit", 32'(commit), 1);
      tick();
      chk("step_wait_state", 32'(state), 6);
      tick();
      chk("step_wait_hold",  32'(state), 6);
      chk("step_wait_stay",  32'(stay), 1);
      chk("step_wait_imem",  32'(m.imem_req), 0);
      step = 1'b1;
      tick();
      step      = 1'b0;
      step_mode = 1'b0;
      chk("step_go_state", 32'(state), 1);
`endif

      // disabled timeout: the second instance sits in FETCH forever
      repeat (40) tick();
      chk("nt_state", 32'(nt_state), 1);
      chk("nt_fault", 32'(nt_fault), 0);
      chk("nt_retire", nt_retire_cnt, 0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
